alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001: Module SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst_n  input  1  synchronous active-low reset.
REQ-004: req0_valid / req1_valid  input  1  requester N presents an ALU operation.
REQ-005: req0_in1, req0_in2 / req1_in1, req1_in2  input  32  operands for requester N.
REQ-006: req0_op / req1_op  input  3  ALU opcode: 3'b010 add, 3'b110 sub, any other value gives result 0.
REQ-007: req0_ready / req1_ready  output  1  grant; a request is accepted on the cycle where valid and ready are both high.
REQ-008: rsp0_valid / rsp1_valid  output  1  result for requester N is held on rsp_out and rsp_zero.
REQ-009: rsp0_ready / rsp1_ready  input  1  requester N consumes its response.
REQ-010: rsp_out  output  32  registered ALU result; rsp_zero  output  1  set to 1 exactly when rsp_out == 0.
REQ-011: grant_cnt0 / grant_cnt1  output  16  accepted-request count per requester, saturating at 16'hFFFF.

Function
REQ-012: FSM SHALL have two states: IDLE (no response pending) and RESP (one response held).
REQ-013: In IDLE, readies are driven combinationally from the valids; at most one ready is high per cycle.
REQ-014: Only req0_valid high -> req0_ready=1. Only req1_valid high -> req1_ready=1.
REQ-015: Both valid -> grant the requester not recorded in last_grant (round-robin).
REQ-016: Neither valid -> both readies 0.
REQ-017: In RESP, both readies SHALL be 0.
REQ-018: On acceptance, the ALU result of the granted operands SHALL be computed in the same cycle and registered into rsp_out / rsp_zero.
  - Add and sub are modulo 2^32; carry and borrow are discarded.
REQ-019: On acceptance, last_grant SHALL be updated to the granted index and the FSM SHALL go to RESP.
  - Next cycle, rsp<N>_valid=1 for the granted N only (1-cycle latency from acceptance to response).
REQ-020: In RESP, rsp_out, rsp_zero and rsp<N>_valid SHALL hold stable until rsp<N>_ready=1.
  - On that cycle, the FSM returns to IDLE and rsp<N>_valid drops on the next cycle.
REQ-021: rsp_ready of the non-owning requester SHALL be ignored.
REQ-022: No new request is accepted in the cycle the response is consumed.
  - Minimum issue interval per accepted op is 2 cycles.
REQ-023: Operand or op changes while a requester waits ungranted SHALL have no effect; only values present at acceptance are used.
REQ-024: grant_cnt<N> SHALL increment by 1 on each acceptance for requester N and saturate at 16'hFFFF (no wrap).
REQ-025: At most one rsp_valid SHALL ever be high.
  - rsp_out / rsp_zero are don't-care-stable (hold last value) while no rsp_valid is high.

Reset
REQ-026: When rst_n=0 at a rising clk edge, the following SHALL be set, regardless of state:
  - FSM to IDLE.
  - rsp0_valid=0, rsp1_valid=0.
  - rsp_out=0, rsp_zero=1.
  - grant_cnt0=0, grant_cnt1=0.
  - last_grant=1, so req0 wins the first contended cycle.
REQ-027: Reset asserted while in RESP SHALL discard the pending response, with no rsp_valid in the following cycle.
REQ-028: While rst_n=0, req0_ready and req1_ready SHALL be 0.

Verification
REQ-029: Single add: req0 valid, in1=5, in2=7, op=010 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp_out=12, rsp_zero=0, grant_cnt0=1.
REQ-030: Sub to zero with stall: req1 in1=in2=32'h1234, op=110; rsp1_ready held 0 for 3 cycles -> rsp1_valid, rsp_out=0 and rsp_zero=1 stable for those 3 cycles; after rsp1_ready=1, rsp1_valid=0 next cycle.
REQ-031: Contention: both valid continuously after reset, rsp_ready tied 1 -> grants in order req0, req1, req0, req1, one every 2 cycles; readies never both high.
REQ-032: Wrap and default op: in1=32'hFFFFFFFF, in2=1, op=010 -> rsp_out=0, rsp_zero=1; op=111 with any operands -> rsp_out=0.
REQ-033: Reset mid-operation: accept req0 add, assert rst_n=0 in the RESP cycle -> next cycle rsp0_valid=0, rsp_out=0, grant_cnt0=0, FSM in IDLE; the first contended grant afterwards goes to req0.
REQ-034: Saturation: force 65537 accepts from req1 -> grant_cnt1=16'hFFFF and remains there.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter -- two-requester round-robin front end for a shared 32-bit ALU.
//
// Each requester presents an operation (valid, in1, in2, op). One request is
// accepted at a time. The result is registered and held for the owner until
// that owner consumes it with rsp<N>_ready. Only then can the next request be
// accepted. Contended cycles alternate between the two requesters.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   req<N>_valid/_ready      request handshake (ready is combinational in IDLE)
//   req<N>_in1/_in2/_op      operands and opcode (010 add, 110 sub, else 0)
//   rsp<N>_valid/_ready      response handshake for requester N
//   rsp_out, rsp_zero        registered result, and a flag for result == 0
//   grant_cnt0/1             per-requester accept counters, saturating
//
// CNT_W sets the counter width. The default of 16 gives the architectural
// 16'hFFFF saturation point.

// Saturating accept counter, one instance per requester.
module alu_arb_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    // Stop at all-ones rather than wrapping back to zero.
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_in1,
  input  logic [31:0]      req0_in2,
  input  logic [2:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_in1,
  input  logic [31:0]      req1_in2,
  input  logic [2:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  // shared response data
  output logic [31:0]      rsp_out,
  output logic             rsp_zero,
  // statistics
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,  // no response pending, arbitration active
    RESP = 1'b1   // one result held for its owner
  } state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] in1;
  } alu_req_t;

  // Gather the per-requester ports into arrays so the logic below is
  // indexed by requester rather than duplicated.
  alu_req_t [NUM_REQ-1:0]              req;
  logic     [NUM_REQ-1:0]              req_vld;
  logic     [NUM_REQ-1:0]              gnt;
  logic     [NUM_REQ-1:0]              rsp_rdy;
  logic     [NUM_REQ-1:0]              rsp_vld;
  logic     [NUM_REQ-1:0][CNT_W-1:0]   grant_cnt;

  assign req[0]  = alu_req_t'{op: req0_op, in2: req0_in2, in1: req0_in1};
  assign req[1]  = alu_req_t'{op: req1_op, in2: req1_in2, in1: req1_in1};
  assign req_vld = {req1_valid, req0_valid};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};

  // State
  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // index of the last winner
  logic              owner_q, owner_d;            // index owning the held result
  logic [DATA_W-1:0] rsp_out_q, rsp_out_d;
  logic              rsp_zero_q, rsp_zero_d;

  // ALU: add and sub wrap modulo 2^32; any other opcode yields zero.
  function automatic logic [DATA_W-1:0] alu_eval(input alu_req_t r);
    case (r.op)
      OP_ADD:  return r.in1 + r.in2;
      OP_SUB:  return r.in1 - r.in2;
      default: return '0;
    endcase
  endfunction

  // Arbitration. Grants happen only in IDLE and never while reset is held.
  // A lone valid wins outright. When both are valid, the one that did not
  // win last time is chosen. The grant vector is the ready vector.
  always_comb begin
    gnt = '0;
    if (rst_n && (state_q == IDLE)) begin
      if (req_vld == 2'b11) gnt = last_grant_q ? 2'b01 : 2'b10;
      else                  gnt = req_vld;
    end
  end

  logic              sel;
  alu_req_t          acc_req;
  logic [DATA_W-1:0] alu_res;

  assign sel     = gnt[1];
  assign acc_req = req[sel];
  assign alu_res = alu_eval(acc_req);

  // Next-state / datapath
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    rsp_out_d    = rsp_out_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      IDLE: begin
        // Operands are captured only here, so earlier changes on a waiting
        // requester are never seen.
        if (|gnt) begin
          state_d      = RESP;
          last_grant_d = sel;
          owner_d      = sel;
          rsp_out_d    = alu_res;
          rsp_zero_d   = (alu_res == '0);
        end
      end
      RESP: begin
        // Only the owner's ready matters. Readies stay low in this state,
        // so nothing new is accepted on the consume cycle.
        if (rsp_rdy[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;   // req0 wins the first contended cycle
      owner_q      <= 1'b0;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      rsp_out_q    <= rsp_out_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  // Per-requester response valid and accept counter.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign rsp_vld[i] = (state_q == RESP) && (owner_q == 1'(i));

    alu_arb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (gnt[i]),
      .cnt   (grant_cnt[i])
    );
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp_out    = rsp_out_q;
  assign rsp_zero   = rsp_zero_q;
  assign grant_cnt0 = grant_cnt[0];
  assign grant_cnt1 = grant_cnt[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. The counter width is reduced to 8 bits
// so that the saturation scenario fits in a few hundred cycles. The
// saturating logic is the same for any width.
module tb_alu_arbiter;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [31:0]   req0_in1, req0_in2, req1_in1, req1_in2;
  logic [2:0]    req0_op, req1_op;
  logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0]   rsp_out;
  logic          rsp_zero;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in1   (req0_in1),
    .req0_in2   (req0_in2),
    .req0_op    (req0_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in1   (req1_in1),
    .req1_in2   (req1_in2),
    .req1_op    (req1_op),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_out    (rsp_out),
    .rsp_zero   (rsp_zero),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_in1 = 0; req0_in2 = 0; req0_op = 0;
    req1_in1 = 0; req1_in2 = 0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    req0_valid = 1; req1_valid = 1;
    tick();
    tick();
    n_chk++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++;
      $display("FAIL reset_ready: got %b exp 00", {req1_ready, req0_ready}); end
    n_chk++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_fail++;
      $display("FAIL reset_rsp_valid: got %b exp 00", {rsp1_valid, rsp0_valid}); end
    n_chk++; if (rsp_out !== 32'd0 || rsp_zero !== 1'b1) begin n_fail++;
      $display("FAIL reset_rsp: got out=%0h zero=%b exp 0/1", rsp_out, rsp_zero); end
    n_chk++; if (grant_cnt0 !== 0 || grant_cnt1 !== 0) begin n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d exp 0/0", grant_cnt0, grant_cnt1); end
    clear_inputs();
    rst_n = 1;
    #1;
  endtask

  // 5 + 7 from req0, accepted at once, result one cycle later.
  task automatic test_single_add();
    req0_valid = 1; req0_in1 = 5; req0_in2 = 7; req0_op = 3'b010;
    #1;
    n_chk++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++;
      $display("FAIL add_ready: got %b exp 01", {req1_ready, req0_ready}); end
    tick();
    n_chk++; if ({rsp1_valid, rsp0_valid} !== 2'b01) begin n_fail++;
      $display("FAIL add_rsp_valid: got %b exp 01", {rsp1_valid, rsp0_valid}); end
    n_chk++; if (rsp_out !== 32'd12 || rsp_zero !== 1'b0) begin n_fail++;
      $display("FAIL add_rsp: got out=%0d zero=%b exp 12/0", rsp_out, rsp_zero); end
    n_chk++; if (grant_cnt0 !== 8'd1) begin n_fail++;
      $display("FAIL add_cnt0: got %0d exp 1", grant_cnt0); end
    // Valid is still high, but no ready is given while a response is held.
    n_chk++; if (req0_ready !== 1'b0) begin n_fail++;
      $display("FAIL add_resp_ready: got %b exp 0", req0_ready); end
    req0_valid = 0;
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    n_chk++; if (rsp0_valid !== 1'b0) begin n_fail++;
      $display("FAIL add_consume: got rsp0_valid=%b exp 0", rsp0_valid); end
  endtask

  // 0x1234 - 0x1234 from req1, held for three cycles. During the hold,
  // rsp0_ready from the non-owner is applied and must be ignored.
  task automatic test_sub_stall();
    req1_valid = 1; req1_in1 = 32'h1234; req1_in2 = 32'h1234; req1_op = 3'b110;
    #1;
    n_chk++; if ({req1_ready, req0_ready} !== 2'b10) begin n_fail++;
      $display("FAIL sub_ready: got %b exp 10", {req1_ready, req0_ready}); end
    tick();
    req1_valid = 0;
    rsp0_ready = 1;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_out !== 32'd0 || rsp_zero !== 1'b1) begin
        n_fail++;
        $display("FAIL sub_hold%0d: got v1=%b v0=%b out=%0h zero=%b exp 1/0/0/1",
                 k, rsp1_valid, rsp0_valid, rsp_out, rsp_zero);
      end
      tick();
    end
    rsp0_ready = 0;
    rsp1_ready = 1;
    tick();
    rsp1_ready = 0;
    n_chk++; if (rsp1_valid !== 1'b0) begin n_fail++;
      $display("FAIL sub_consume: got rsp1_valid=%b exp 0", rsp1_valid); end
    n_chk++; if (grant_cnt1 !== 8'd1 || grant_cnt0 !== 8'd1) begin n_fail++;
      $display("FAIL sub_cnt: got %0d/%0d exp 1/1", grant_cnt0, grant_cnt1); end
  endtask

  // Wrap to zero, a nonzero result, then an undefined opcode.
  task automatic test_wrap_default();
    req0_valid = 1; req0_in1 = 32'hFFFF_FFFF; req0_in2 = 1; req0_op = 3'b010;
    tick();
    req0_valid = 0;
    n_chk++; if (rsp_out !== 32'd0 || rsp_zero !== 1'b1) begin n_fail++;
      $display("FAIL wrap: got out=%0h zero=%b exp 0/1", rsp_out, rsp_zero); end
    rsp0_ready = 1; tick(); rsp0_ready = 0;

    req1_valid = 1; req1_in1 = 3; req1_in2 = 4; req1_op = 3'b010;
    tick();
    req1_valid = 0;
    n_chk++; if (rsp_out !== 32'd7 || rsp_zero !== 1'b0) begin n_fail++;
      $display("FAIL add7: got out=%0h zero=%b exp 7/0", rsp_out, rsp_zero); end
    rsp1_ready = 1; tick(); rsp1_ready = 0;

    req0_valid = 1; req0_in1 = 9; req0_in2 = 9; req0_op = 3'b111;
    tick();
    req0_valid = 0;
    n_chk++; if (rsp_out !== 32'd0 || rsp_zero !== 1'b1 || rsp0_valid !== 1'b1) begin n_fail++;
      $display("FAIL op111: got out=%0h zero=%b v0=%b exp 0/1/1", rsp_out, rsp_zero, rsp0_valid); end
    rsp0_ready = 1; tick(); rsp0_ready = 0;
  endtask

  // From reset, with both valid and both rsp_ready high, grants alternate
  // req0, req1, ... with one grant every two cycles.
  task automatic test_contention();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_out;
    logic [1:0]  exp_vld;
    do_reset();
    req0_valid = 1; req0_in1 = 10; req0_in2 = 1; req0_op = 3'b010;  // 11
    req1_valid = 1; req1_in1 = 10; req1_in2 = 1; req1_op = 3'b110;  // 9
    rsp0_ready = 1; rsp1_ready = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_rdy = (k % 2 == 1) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
      n_chk++; if ({req1_ready, req0_ready} !== exp_rdy) begin n_fail++;
        $display("FAIL contend_ready%0d: got %b exp %b", k, {req1_ready, req0_ready}, exp_rdy); end
      if (k % 2 == 1) begin
        exp_vld = (((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
        exp_out = (exp_vld == 2'b01) ? 32'd11 : 32'd9;
        n_chk++; if ({rsp1_valid, rsp0_valid} !== exp_vld || rsp_out !== exp_out) begin n_fail++;
          $display("FAIL contend_rsp%0d: got v=%b out=%0d exp v=%b out=%0d",
                   k, {rsp1_valid, rsp0_valid}, rsp_out, exp_vld, exp_out); end
      end
      tick();
    end
    clear_inputs();
    n_chk++; if (grant_cnt0 !== 8'd2 || grant_cnt1 !== 8'd2) begin n_fail++;
      $display("FAIL contend_cnt: got %0d/%0d exp 2/2", grant_cnt0, grant_cnt1); end
    tick();
  endtask

  // Operands of a waiting requester change while it waits. The values
  // present when it is granted are the ones used. No accept happens on the
  // consume cycle.
  task automatic test_back_to_back();
    do_reset();
    req0_valid = 1; req0_in1 = 1;   req0_in2 = 2;   req0_op = 3'b010;
    req1_valid = 1; req1_in1 = 100; req1_in2 = 200; req1_op = 3'b010;
    #1;
    n_chk++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++;
      $display("FAIL b2b_first: got %b exp 01", {req1_ready, req0_ready}); end
    tick();
    req1_in1 = 50; req1_in2 = 8; req1_op = 3'b110;
    rsp0_ready = 1;
    #1;
    n_chk++; if ({req1_ready, req0_ready} !== 2'b00 || rsp_out !== 32'd3) begin n_fail++;
      $display("FAIL b2b_consume: got rdy=%b out=%0d exp 00/3", {req1_ready, req0_ready}, rsp_out); end
    tick();
    rsp0_ready = 0;
    #1;
    n_chk++; if ({req1_ready, req0_ready} !== 2'b10) begin n_fail++;
      $display("FAIL b2b_second: got %b exp 10", {req1_ready, req0_ready}); end
    tick();
    req1_in1 = 7; req1_in2 = 7; req1_op = 3'b010;
    #1;
    n_chk++; if (rsp1_valid !== 1'b1 || rsp_out !== 32'd42) begin n_fail++;
      $display("FAIL b2b_result: got v1=%b out=%0d exp 1/42", rsp1_valid, rsp_out); end
    tick();
    n_chk++; if (rsp_out !== 32'd42) begin n_fail++;
      $display("FAIL b2b_hold: got out=%0d exp 42", rsp_out); end
    clear_inputs();
    rsp1_ready = 1; tick(); rsp1_ready = 0;
  endtask

  // Reset in the RESP cycle drops the pending response. The next contended
  // grant goes to req0.
  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1; req0_in1 = 20; req0_in2 = 22; req0_op = 3'b010;
    tick();
    req0_valid = 0;
    n_chk++; if (rsp0_valid !== 1'b1 || rsp_out !== 32'd42) begin n_fail++;
      $display("FAIL mid_pre: got v0=%b out=%0d exp 1/42", rsp0_valid, rsp_out); end
    rst_n = 0;
    req0_valid = 1; req1_valid = 1;
    #1;
    n_chk++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++;
      $display("FAIL mid_rst_ready: got %b exp 00", {req1_ready, req0_ready}); end
    tick();
    n_chk++; if (rsp0_valid !== 1'b0 || rsp_out !== 32'd0 || rsp_zero !== 1'b1 || grant_cnt0 !== 0) begin
      n_fail++;
      $display("FAIL mid_rst_state: got v0=%b out=%0d zero=%b cnt0=%0d exp 0/0/1/0",
               rsp0_valid, rsp_out, rsp_zero, grant_cnt0);
    end
    rst_n = 1;
    #1;
    n_chk++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++;
      $display("FAIL mid_first_grant: got %b exp 01", {req1_ready, req0_ready}); end
    tick();
    clear_inputs();
    rsp0_ready = 1; tick(); rsp0_ready = 0;
  endtask

  // req1 issues continuously. The counter counts up and then sticks at
  // all-ones.
  task automatic test_saturation();
    do_reset();
    req1_valid = 1; req1_in1 = 1; req1_in2 = 1; req1_op = 3'b010;
    rsp1_ready = 1;
    repeat (508) tick();   // 254 accepts
    n_chk++; if (grant_cnt1 !== 8'hFE) begin n_fail++;
      $display("FAIL sat_pre: got %0h exp fe", grant_cnt1); end
    repeat (12) tick();    // 260 accepts in total
    n_chk++; if (grant_cnt1 !== 8'hFF || grant_cnt0 !== 8'h00) begin n_fail++;
      $display("FAIL sat_hold: got cnt1=%0h cnt0=%0h exp ff/0", grant_cnt1, grant_cnt0); end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_single_add();
    test_sub_stall();
    test_wrap_default();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Invariants checked every cycle. They are counted into the same
  // totals as the directed checks.
  always @(negedge clk) begin
    if (req0_ready && req1_ready) begin
      n_chk++; n_fail++;
      $display("FAIL both_ready: got 11 exp at most one");
    end
    if (rsp0_valid && rsp1_valid) begin
      n_chk++; n_fail++;
      $display("FAIL both_rsp_valid: got 11 exp at most one");
    end
  end

endmodule
